// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard_ctrl pipeline sequencing controller.
package hazard_pkg;

  // Default register index width (RV32: 32 architectural registers)
  localparam int REG_W_DEFAULT = 5;

  // Drain counter width, sized for the largest legal DRAIN_CYCLES (7)
  localparam int CNT_W = $clog2(8);

  // Controller states; encodings are visible on the debug state port
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: decoder control bits from
// ID/EX plus the resume request in, stall/flush/status out.
// The controller connects through the slave modport, the pipeline through master.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_readsreg;
  logic             id_pause;
  logic             ex_valid;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memtoreg;
  logic             ex_writesreg;
  logic             ex_jump;
  logic             resume;
  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             flush_ex;
  logic             paused;
  logic [1:0]       state;

  modport master (
    output id_valid, id_rs1, id_rs2, id_readsreg, id_pause,
    output ex_valid, ex_rd, ex_memtoreg, ex_writesreg, ex_jump,
    output resume,
    input  stall_if, stall_id, flush_id, flush_ex, paused, state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_readsreg, id_pause,
    input  ex_valid, ex_rd, ex_memtoreg, ex_writesreg, ex_jump,
    input  resume,
    output stall_if, stall_id, flush_id, flush_ex, paused, state
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
// Flags an EX load whose destination feeds a source of the ID instruction.
// x0 is hardwired to zero, so a load targeting it never creates a hazard.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             ex_valid,
  input  logic             ex_memtoreg,
  input  logic             ex_writesreg,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic             id_readsreg,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             load_use
);

  // Hazard when a live load writes a nonzero rd that the live ID instruction reads
  always_comb begin
    load_use = ex_valid && ex_memtoreg && ex_writesreg && (ex_rd != '0) &&
               id_valid && id_readsreg &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage core.
// Handles load-use stalls, EX-resolved jump redirects and the PAUSE
// drain/hold/resume sequence. All outputs are combinational from the
// registered state, the drain counter and the current inputs.
// Optional build macro HAZARD_STATS_EN adds 32-bit wrapping event counters
// (stall_cnt, flush_cnt, pause_cnt).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_W        = REG_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt,
  output logic [31:0]  pause_cnt
`endif
);

  // The PAUSE cycle in RUN is the first bubble; DRAIN supplies the rest
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             jmp;
  logic             stall_if_c, stall_id_c, flush_id_c, flush_ex_c, paused_c;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_valid     (bus.ex_valid),
    .ex_memtoreg  (bus.ex_memtoreg),
    .ex_writesreg (bus.ex_writesreg),
    .ex_rd        (bus.ex_rd),
    .id_valid     (bus.id_valid),
    .id_readsreg  (bus.id_readsreg),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .load_use     (load_use)
  );

  assign jmp = bus.ex_valid && bus.ex_jump;

  // Next-state and output decode; reset forces every output low and state to RUN
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    flush_id_c = 1'b0;
    flush_ex_c = 1'b0;
    paused_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jmp) begin
          // Redirect wins: anything in IF/ID is wrong-path, including a PAUSE
          flush_id_c = 1'b1;
          flush_ex_c = 1'b1;
        end else if (load_use) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          flush_ex_c = 1'b1;
        end else if (bus.id_valid && bus.id_pause) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          flush_ex_c = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = (DRAIN_CYCLES == 1) ? ST_PAUSED : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // EX holds only bubbles here, so hazards are irrelevant; resume is dropped
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        flush_ex_c = 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        flush_ex_c = 1'b1;
        paused_c   = 1'b1;
        if (bus.resume) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        // Retire the PAUSE still held in IF/ID and let fetch run again
        flush_id_c = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      stall_if_c = 1'b0;
      stall_id_c = 1'b0;
      flush_id_c = 1'b0;
      flush_ex_c = 1'b0;
      paused_c   = 1'b0;
    end
  end

  // State and drain counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_if = stall_if_c;
  assign bus.stall_id = stall_id_c;
  assign bus.flush_id = flush_id_c;
  assign bus.flush_ex = flush_ex_c;
  assign bus.paused   = paused_c;
  assign bus.state    = reset ? ST_RUN : state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] pause_cnt_q, pause_cnt_d;

  // Event counter increments; counters wrap naturally at 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pause_cnt_d = pause_cnt_q;
    if (state_q == ST_RUN && jmp)                   flush_cnt_d = flush_cnt_q + 32'd1;
    if (state_q == ST_RUN && !jmp && load_use)      stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_q != ST_PAUSED && state_d == ST_PAUSED) pause_cnt_d = pause_cnt_q + 32'd1;
  end

  // Event counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      pause_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign pause_cnt = pause_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Consumes the decoder's control bits (memtoreg, writesreg, readsreg, jump, pause) from the ID and EX stages.
- Drives per-stage stall and flush enables.
- Resolves load-use hazards and jump redirects, and runs the PAUSE sequence: drain, hold, resume.

Parameters:
- DRAIN_CYCLES, 3, bubbles inserted after a PAUSE reaches ID before the core counts as paused (EX, MEM, WB); legal range 1..7.
- REG_W, 5, register index width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_W  ID source register 1
- id_rs2  in  REG_W  ID source register 2
- id_readsreg  in  1  ID instruction reads sources
- id_pause  in  1  ID instruction is PAUSE
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  REG_W  EX destination register
- ex_memtoreg  in  1  EX instruction is a load
- ex_writesreg  in  1  EX instruction writes rd
- ex_jump  in  1  EX instruction is JAL/JALR (redirect resolved in EX)
- resume  in  1  external request to leave PAUSED
- stall_if  out  1  hold PC/IF register
- stall_id  out  1  hold IF/ID register
- flush_id  out  1  clear IF/ID to bubble
- flush_ex  out  1  clear ID/EX to bubble
- paused  out  1  core quiescent in PAUSED
- state  out  2  current FSM state, for debug

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. Reset takes precedence over every event and is also legal mid-DRAIN or mid-PAUSED.
- Reset values: state=RUN, drain counter=0. While reset is high, all outputs are 0 and state reads RUN.
- FSM states (2-bit): RUN=0, DRAIN=1, PAUSED=2, RESUME=3.
- Output timing: all outputs are combinational from the registered state, the counter and the current inputs. Zero-cycle latency.
- load_use = ex_valid & ex_memtoreg & ex_writesreg & ex_rd!=0 & id_valid & id_readsreg & (ex_rd==id_rs1 | ex_rd==id_rs2).
- jmp = ex_valid & ex_jump.
- RUN, priority order:
  - jmp: flush_id=1, flush_ex=1, no stall. Any PAUSE or load-use sitting in ID is discarded; stay in RUN.
  - load_use: stall_if=1, stall_id=1, flush_ex=1 for exactly that cycle; stay in RUN.
  - id_valid & id_pause: stall_if=1, stall_id=1, flush_ex=1; counter<=DRAIN_CYCLES-1. Next state is DRAIN, or PAUSED directly if DRAIN_CYCLES==1.
  - otherwise: all outputs 0.
- DRAIN:
  - stall_if=1, stall_id=1, flush_ex=1.
  - Counter decrements each cycle; when the counter is 0, next state is PAUSED.
  - resume is ignored here and not latched.
- PAUSED:
  - stall_if=1, stall_id=1, flush_ex=1, paused=1.
  - resume=1 moves to RESUME next cycle.
- RESUME, one cycle:
  - flush_id=1 retires the PAUSE held in ID; stalls=0, flush_ex=0.
  - Next state is RUN.
- resume in RUN or RESUME: ignored.
- Inputs in DRAIN/PAUSED: load_use and jmp are masked, since EX only holds bubbles.
- Register 0: ex_rd==0 never creates a hazard.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds three 32-bit outputs, all wrapping and reset to 0:
  - stall_cnt: +1 per cycle load_use stalls in RUN.
  - flush_cnt: +1 per jmp flush.
  - pause_cnt: +1 per entry into PAUSED.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN/DRAIN/PAUSED/RESUME, 2-bit);
  - the counter width localparam, $clog2(8);
  - REG_W default 5.
- One sub-module, load_use_detect: purely combinational comparator producing load_use from the ID/EX fields. Instantiated once.

Test Plan:
- Load-use: ex_valid=1, memtoreg=1, writesreg=1, ex_rd=5; id_valid=1, readsreg=1, id_rs2=5 → single cycle of stall_if=stall_id=flush_ex=1; with ex_rd=0 instead → all outputs 0.
- Jump vs pause: ex_jump=1 together with id_pause=1 → flush_id=flush_ex=1, state stays RUN, paused never asserts.
- Pause drain: id_pause=1 with DRAIN_CYCLES=3 → state RUN, DRAIN, DRAIN, PAUSED on consecutive cycles; stalls held throughout; paused=1 from the 4th cycle.
- Resume: resume=1 during DRAIN → ignored. resume=1 in PAUSED → next cycle RESUME with flush_id=1 and stalls 0, then RUN.
- Reset mid-operation: reset=1 in the second DRAIN cycle → next state RUN, counter 0, all outputs 0 while reset is high.
- HAZARD_STATS_EN: 2 load-use cycles, 1 jump, 1 pause/resume → stall_cnt=2, flush_cnt=1, pause_cnt=1.
